// File: rtl/apb_slave_mem.sv
// apb_slave_mem
//   APB3 completer backed by a word-addressed register array. A transfer is
//   captured in the setup phase, held for WAIT_STATES extra ACCESS cycles,
//   then completed with a one-cycle pready pulse. Misaligned or out-of-range
//   addresses complete with pslverr and never touch the array.
//
// Ports
//   pclk_i      bus clock, all state on the rising edge
//   preset_ni   asynchronous active-low reset
//   psel_i      slave select
//   penable_i   access phase strobe
//   pwrite_i    1 = write, 0 = read
//   paddr_i     byte address
//   pwdata_i    write data
//   prdata_o    read data, non-zero only on a successful read completion
//   pready_o    transfer completes at this edge
//   pslverr_o   error response, only asserted together with pready_o

module apb_slave_mem #(
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned DEPTH       = 64,
    parameter int unsigned WAIT_STATES = 2
) (
    input  logic                  pclk_i,
    input  logic                  preset_ni,
    input  logic                  psel_i,
    input  logic                  penable_i,
    input  logic                  pwrite_i,
    input  logic [ADDR_WIDTH-1:0] paddr_i,
    input  logic [DATA_WIDTH-1:0] pwdata_i,
    output logic [DATA_WIDTH-1:0] prdata_o,
    output logic                  pready_o,
    output logic                  pslverr_o
);

    localparam int unsigned IdxW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CntW = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;

    typedef enum logic [0:0] {StIdle, StAccess} state_e;

    state_e                state_q, state_d;
    logic [CntW-1:0]       cnt_q, cnt_d;
    logic [IdxW-1:0]       idx_q;
    logic                  write_q;
    logic                  err_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic                  setup;
    logic                  addr_err;
    logic                  commit;

    // Misaligned, or any word index past the array (upper bits included).
    assign addr_err = (paddr_i[1:0] != 2'b00) ||
                      ({2'b00, paddr_i[ADDR_WIDTH-1:2]} >= ADDR_WIDTH'(DEPTH));

    assign setup = (state_q == StIdle) && psel_i && !penable_i;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (setup) begin
                    state_d = StAccess;
                    cnt_d   = CntW'(WAIT_STATES);
                end
            end
            StAccess: begin
                if (!psel_i) begin
                    // Master abandoned the transfer: drop it without a response.
                    state_d = StIdle;
                    cnt_d   = '0;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - CntW'(1);
                end else begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge pclk_i or negedge preset_ni) begin
        if (!preset_ni) begin
            state_q <= StIdle;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Bus fields are captured only at setup; later changes are ignored.
    always_ff @(posedge pclk_i or negedge preset_ni) begin
        if (!preset_ni) begin
            idx_q   <= '0;
            write_q <= 1'b0;
            err_q   <= 1'b0;
            wdata_q <= '0;
        end else if (setup) begin
            idx_q   <= paddr_i[IdxW+1:2];
            write_q <= pwrite_i;
            err_q   <= addr_err;
            wdata_q <= pwdata_i;
        end
    end

    assign pready_o  = (state_q == StAccess) && (cnt_q == '0) && psel_i;
    assign pslverr_o = pready_o && err_q;
    assign commit    = pready_o && write_q && !err_q;
    assign prdata_o  = (pready_o && !write_q && !err_q) ? mem_q[idx_q] : '0;

    always_ff @(posedge pclk_i or negedge preset_ni) begin
        if (!preset_ni) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else if (commit) begin
            mem_q[idx_q] <= wdata_q;
        end
    end

endmodule

// File: tb/tb_apb_slave_mem.sv
module tb_apb_slave_mem;

    logic        pclk;
    logic        preset_n;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] paddr;
    logic [31:0] pwdata;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;

    int checks = 0;
    int errors = 0;

    apb_slave_mem #(
        .ADDR_WIDTH (32),
        .DATA_WIDTH (32),
        .DEPTH      (64),
        .WAIT_STATES(2)
    ) dut (
        .pclk_i   (pclk),
        .preset_ni(preset_n),
        .psel_i   (psel),
        .penable_i(penable),
        .pwrite_i (pwrite),
        .paddr_i  (paddr),
        .pwdata_i (pwdata),
        .prdata_o (prdata),
        .pready_o (pready),
        .pslverr_o(pslverr)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        bit          exp_err;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Called just after a rising edge. Returns with psel low, just after the
    // completion edge, so consecutive calls run back-to-back.
    task automatic xfer(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                        output logic [31:0] rdata, output bit err, output int cycles);
        bit done;
        psel    = 1'b1;
        penable = 1'b0;
        pwrite  = wr;
        paddr   = addr;
        pwdata  = wdata;
        @(posedge pclk);
        #1;
        penable = 1'b1;
        cycles  = 1;
        done    = 1'b0;
        rdata   = 'x;
        err     = 1'b0;
        for (int k = 0; k < 20 && !done; k++) begin
            @(negedge pclk);
            cycles++;
            if (pready) begin
                rdata = prdata;
                err   = pslverr;
                done  = 1'b1;
            end
            @(posedge pclk);
            #1;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL timeout addr 0x%08h: no pready within 20 cycles", addr);
            cycles = 0;
        end
        psel    = 1'b0;
        penable = 1'b0;
    endtask

    task automatic read_check(input string name, input logic [31:0] addr,
                              input logic [31:0] exp);
        logic [31:0] rd;
        bit          er;
        int          cy;
        xfer(1'b0, addr, 32'h0, rd, er, cy);
        check({name, " rdata"}, rd, exp);
        check({name, " pslverr"}, 32'(er), 32'h0);
    endtask

    initial begin
        logic [31:0] rd;
        bit          er;
        int          cy;

        psel     = 1'b0;
        penable  = 1'b0;
        pwrite   = 1'b0;
        paddr    = '0;
        pwdata   = '0;
        preset_n = 1'b0;

        // Reset
        repeat (3) @(posedge pclk);
        @(negedge pclk);
        check("reset prdata", prdata, 32'h0);
        check("reset pready", 32'(pready), 32'h0);
        check("reset pslverr", 32'(pslverr), 32'h0);
        @(posedge pclk);
        #1;
        preset_n = 1'b1;

        // Back-to-back directed vectors; every transfer must take 4 cycles.
        vecs.push_back('{0, 32'h0000_0000, 32'h0, 32'h0000_0000, 0});
        vecs.push_back('{1, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0, 0});
        vecs.push_back('{0, 32'h0000_0010, 32'h0, 32'hDEAD_BEEF, 0});
        vecs.push_back('{1, 32'h0000_0100, 32'h1111_1111, 32'h0, 1});
        vecs.push_back('{1, 32'h0000_0012, 32'h2222_2222, 32'h0, 1});
        vecs.push_back('{0, 32'h0000_0100, 32'h0, 32'h0000_0000, 1});
        vecs.push_back('{0, 32'h0000_0010, 32'h0, 32'hDEAD_BEEF, 0});
        vecs.push_back('{1, 32'h8000_0010, 32'h3333_3333, 32'h0, 1});
        vecs.push_back('{0, 32'h0000_0010, 32'h0, 32'hDEAD_BEEF, 0});
        vecs.push_back('{1, 32'h0000_0000, 32'h0000_0001, 32'h0, 0});
        vecs.push_back('{1, 32'h0000_0004, 32'h0000_0002, 32'h0, 0});
        vecs.push_back('{1, 32'h0000_0008, 32'h0000_0003, 32'h0, 0});
        vecs.push_back('{0, 32'h0000_0000, 32'h0, 32'h0000_0001, 0});
        vecs.push_back('{0, 32'h0000_0004, 32'h0, 32'h0000_0002, 0});
        vecs.push_back('{0, 32'h0000_0008, 32'h0, 32'h0000_0003, 0});
        vecs.push_back('{1, 32'h0000_00FC, 32'h0BAD_F00D, 32'h0, 0});
        vecs.push_back('{0, 32'h0000_00FC, 32'h0, 32'h0BAD_F00D, 0});
        vecs.push_back('{0, 32'h0000_0013, 32'h0, 32'h0000_0000, 1});

        for (int i = 0; i < vecs.size(); i++) begin
            string tag;
            tag = $sformatf("vec%0d@%08h", i, vecs[i].addr);
            xfer(vecs[i].wr, vecs[i].addr, vecs[i].wdata, rd, er, cy);
            check({tag, " cycles"}, 32'(cy), 32'd4);
            check({tag, " pslverr"}, 32'(er), 32'(vecs[i].exp_err));
            if (!vecs[i].wr) check({tag, " rdata"}, rd, vecs[i].exp_rdata);
        end

        // Abort: psel dropped while cnt=1, no response and no write.
        psel    = 1'b1;
        penable = 1'b0;
        pwrite  = 1'b1;
        paddr   = 32'h20;
        pwdata  = 32'h1234_5678;
        @(posedge pclk);
        #1;
        penable = 1'b1;
        @(negedge pclk);
        check("abort pready cnt2", 32'(pready), 32'h0);
        @(posedge pclk);
        #1;
        psel = 1'b0;
        @(negedge pclk);
        check("abort pready cnt1", 32'(pready), 32'h0);
        @(posedge pclk);
        #1;
        penable = 1'b0;
        @(negedge pclk);
        check("abort pready after", 32'(pready), 32'h0);
        @(posedge pclk);
        #1;
        read_check("abort readback", 32'h20, 32'h0);

        // Access phase without a setup phase is ignored.
        psel    = 1'b1;
        penable = 1'b1;
        pwrite  = 1'b1;
        paddr   = 32'h24;
        pwdata  = 32'hCAFE_0001;
        begin
            int seen = 0;
            repeat (4) begin
                @(negedge pclk);
                if (pready) seen++;
                @(posedge pclk);
                #1;
            end
            check("no-setup pready count", 32'(seen), 32'h0);
        end
        psel    = 1'b0;
        penable = 1'b0;
        read_check("no-setup readback", 32'h24, 32'h0);

        // Reset asserted in the completing cycle of a write.
        psel    = 1'b1;
        penable = 1'b0;
        pwrite  = 1'b1;
        paddr   = 32'h0C;
        pwdata  = 32'hA5A5_A5A5;
        @(posedge pclk);
        #1;
        penable = 1'b1;
        repeat (2) begin
            @(posedge pclk);
            #1;
        end
        @(negedge pclk);
        check("midreset pready before", 32'(pready), 32'h1);
        #1;
        preset_n = 1'b0;
        #1;
        check("midreset pready", 32'(pready), 32'h0);
        check("midreset pslverr", 32'(pslverr), 32'h0);
        check("midreset prdata", prdata, 32'h0);
        psel    = 1'b0;
        penable = 1'b0;
        repeat (2) @(posedge pclk);
        #1;
        preset_n = 1'b1;
        read_check("midreset readback 0x0C", 32'h0C, 32'h0);
        read_check("midreset readback 0x10", 32'h10, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
